// File: rtl/multicore_processor_top_if.sv
// Register-file write-back bus: the WB stage drives it, the decode-stage register file consumes it.
interface multicore_processor_top_if #(parameter int XLEN = 32);
   logic            we;
   logic [4:0]      waddr;
   logic [XLEN-1:0] wdata;

   modport master (output we, waddr, wdata);
   modport slave  (input  we, waddr, wdata);
endinterface

// File: rtl/multicore_processor_top.sv
// Dual-core RV32I-subset system: two independent 5-stage in-order cores with private ROMs.
// Only ADDI and ADD/SUB/AND/OR/XOR retire; every other encoding behaves as a NOP.
package mcp_pkg;
   localparam logic [31:0] NOP     = 32'h0000_0013;
   localparam logic [6:0]  OP_IMM  = 7'h13;
   localparam logic [6:0]  OP_REG  = 7'h33;
   localparam logic [2:0]  ALU_ADD = 3'd0;
   localparam logic [2:0]  ALU_SUB = 3'd1;
   localparam logic [2:0]  ALU_AND = 3'd2;
   localparam logic [2:0]  ALU_OR  = 3'd3;
   localparam logic [2:0]  ALU_XOR = 3'd4;
endpackage

module mcp_regfile #(parameter int XLEN = 32) (
   input  logic                     clk,
   input  logic                     rst,
   multicore_processor_top_if.slave wb,
   input  logic [4:0]               raddr1_i,
   input  logic [4:0]               raddr2_i,
   output logic [XLEN-1:0]          rdata1_o,
   output logic [XLEN-1:0]          rdata2_o
);
   logic [XLEN-1:0] registers [0:31];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 32; i++) registers[i] <= '0;
      end else if (wb.we && wb.waddr != 5'd0) begin
         registers[wb.waddr] <= wb.wdata;
      end
   end

   // Write-through lets a consumer issue three slots after its producer without forwarding.
   always_comb begin
      rdata1_o = registers[raddr1_i];
      rdata2_o = registers[raddr2_i];
      if (raddr1_i == 5'd0)                        rdata1_o = '0;
      else if (wb.we && wb.waddr == raddr1_i)      rdata1_o = wb.wdata;
      if (raddr2_i == 5'd0)                        rdata2_o = '0;
      else if (wb.we && wb.waddr == raddr2_i)      rdata2_o = wb.wdata;
   end
endmodule

module mcp_if_id (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] if_instruction_in,
   output logic [31:0] id_instruction_out
);
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) id_instruction_out <= mcp_pkg::NOP;
      else      id_instruction_out <= if_instruction_in;
   end
endmodule

module mcp_decode #(parameter int XLEN = 32) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [31:0]              instr_i,
   multicore_processor_top_if.slave wb,
   output logic [XLEN-1:0]          rs1_data_o,
   output logic [XLEN-1:0]          rs2_data_o,
   output logic [XLEN-1:0]          imm_o,
   output logic [4:0]               rd_o,
   output logic                     we_o,
   output logic                     use_imm_o,
   output logic [2:0]               alu_op_o
);
   import mcp_pkg::*;

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;

   assign opcode = instr_i[6:0];
   assign funct3 = instr_i[14:12];
   assign funct7 = instr_i[31:25];
   assign rd_o   = instr_i[11:7];
   assign imm_o  = {{(XLEN-12){instr_i[31]}}, instr_i[31:20]};

   mcp_regfile #(.XLEN(XLEN)) rf (
      .clk      (clk),
      .rst      (rst),
      .wb       (wb),
      .raddr1_i (instr_i[19:15]),
      .raddr2_i (instr_i[24:20]),
      .rdata1_o (rs1_data_o),
      .rdata2_o (rs2_data_o)
   );

   always_comb begin
      we_o      = 1'b0;
      use_imm_o = 1'b0;
      alu_op_o  = ALU_ADD;
      if (opcode == OP_IMM && funct3 == 3'd0) begin
         we_o      = 1'b1;
         use_imm_o = 1'b1;
      end else if (opcode == OP_REG) begin
         case (funct3)
            3'd0: begin
               if (funct7 == 7'h00) we_o = 1'b1;
               else if (funct7 == 7'h20) begin
                  we_o     = 1'b1;
                  alu_op_o = ALU_SUB;
               end
            end
            3'd7: if (funct7 == 7'h00) begin we_o = 1'b1; alu_op_o = ALU_AND; end
            3'd6: if (funct7 == 7'h00) begin we_o = 1'b1; alu_op_o = ALU_OR;  end
            3'd4: if (funct7 == 7'h00) begin we_o = 1'b1; alu_op_o = ALU_XOR; end
            default: ;
         endcase
      end
   end
endmodule

module mcp_mem_wb #(parameter int XLEN = 32) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      we_i,
   input  logic [4:0]                rd_i,
   input  logic [XLEN-1:0]           res_i,
   multicore_processor_top_if.master wb
);
   logic            we_q;
   logic [4:0]      rd_q;
   logic [XLEN-1:0] res_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         we_q  <= 1'b0;
         rd_q  <= '0;
         res_q <= '0;
      end else begin
         we_q  <= we_i;
         rd_q  <= rd_i;
         res_q <= res_i;
      end
   end

   assign wb.we    = we_q;
   assign wb.waddr = rd_q;
   assign wb.wdata = res_q;
endmodule

module mcp_core #(
   parameter int XLEN       = 32,
   parameter int IMEM_DEPTH = 16,
   parameter int CORE_ID    = 0
) (
   input logic clk,
   input logic rst
);
   import mcp_pkg::*;
   localparam int AW = $clog2(IMEM_DEPTH);

   // PC kept as a word index; the byte PC is {pc_q, 2'b00}, so PC += 4 is a word increment.
   logic [29:0]     pc_q, pc_d;
   logic [31:0]     fetch_instr, id_instr;
   logic [XLEN-1:0] dec_a, dec_b, dec_imm;
   logic [4:0]      dec_rd;
   logic            dec_we, dec_use_imm;
   logic [2:0]      dec_op;

   logic [XLEN-1:0] ie_a_q, ie_b_q, ie_imm_q;
   logic [4:0]      ie_rd_q;
   logic            ie_we_q, ie_use_imm_q;
   logic [2:0]      ie_op_q;
   logic [XLEN-1:0] ex_opb, ex_res;
   logic [XLEN-1:0] em_res_q;
   logic [4:0]      em_rd_q;
   logic            em_we_q;

   multicore_processor_top_if #(.XLEN(XLEN)) wb_bus ();

   function automatic logic [31:0] rom_word(input logic [AW-1:0] idx);
      logic [31:0] w;
      w = NOP;
      case (int'(idx))
         0: w = (CORE_ID == 0) ? 32'h0050_0093 : 32'h00C0_0093;
         1: w = (CORE_ID == 0) ? 32'h00A0_0113 : 32'h00F0_0113;
         5: w = 32'h0020_81B3;
         default: w = NOP;
      endcase
      return w;
   endfunction

   assign pc_d        = pc_q + 30'd1;
   assign fetch_instr = (pc_q < 30'(IMEM_DEPTH)) ? rom_word(pc_q[AW-1:0]) : NOP;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) pc_q <= '0;
      else      pc_q <= pc_d;
   end

   mcp_if_id if_id (
      .clk                (clk),
      .rst                (rst),
      .if_instruction_in  (fetch_instr),
      .id_instruction_out (id_instr)
   );

   mcp_decode #(.XLEN(XLEN)) decode_stage (
      .clk        (clk),
      .rst        (rst),
      .instr_i    (id_instr),
      .wb         (wb_bus),
      .rs1_data_o (dec_a),
      .rs2_data_o (dec_b),
      .imm_o      (dec_imm),
      .rd_o       (dec_rd),
      .we_o       (dec_we),
      .use_imm_o  (dec_use_imm),
      .alu_op_o   (dec_op)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ie_a_q       <= '0;
         ie_b_q       <= '0;
         ie_imm_q     <= '0;
         ie_rd_q      <= '0;
         ie_we_q      <= 1'b0;
         ie_use_imm_q <= 1'b0;
         ie_op_q      <= ALU_ADD;
         em_res_q     <= '0;
         em_rd_q      <= '0;
         em_we_q      <= 1'b0;
      end else begin
         ie_a_q       <= dec_a;
         ie_b_q       <= dec_b;
         ie_imm_q     <= dec_imm;
         ie_rd_q      <= dec_rd;
         ie_we_q      <= dec_we;
         ie_use_imm_q <= dec_use_imm;
         ie_op_q      <= dec_op;
         em_res_q     <= ex_res;
         em_rd_q      <= ie_rd_q;
         em_we_q      <= ie_we_q;
      end
   end

   always_comb begin
      ex_opb = ie_use_imm_q ? ie_imm_q : ie_b_q;
      case (ie_op_q)
         ALU_SUB: ex_res = ie_a_q - ex_opb;
         ALU_AND: ex_res = ie_a_q & ex_opb;
         ALU_OR:  ex_res = ie_a_q | ex_opb;
         ALU_XOR: ex_res = ie_a_q ^ ex_opb;
         default: ex_res = ie_a_q + ex_opb;
      endcase
   end

   // MEM has no data memory; the MEM/WB register drives the write-back bus directly.
   mcp_mem_wb #(.XLEN(XLEN)) mem_wb (
      .clk   (clk),
      .rst   (rst),
      .we_i  (em_we_q),
      .rd_i  (em_rd_q),
      .res_i (em_res_q),
      .wb    (wb_bus)
   );
endmodule

module multicore_processor_top #(
   parameter int XLEN       = 32,
   parameter int IMEM_DEPTH = 16
) (
   input logic clk,
   input logic rst
);
   mcp_core #(.XLEN(XLEN), .IMEM_DEPTH(IMEM_DEPTH), .CORE_ID(0)) core0 (.clk(clk), .rst(rst));
   mcp_core #(.XLEN(XLEN), .IMEM_DEPTH(IMEM_DEPTH), .CORE_ID(1)) core1 (.clk(clk), .rst(rst));
endmodule

// File: tb/tb_multicore_processor_top.sv
// Bench for the dual-core system: an ISA-level model replays each ROM one instruction per
// cycle (writeback at cycle k+5) and is compared against both cores every cycle, with random resets.
module tb_multicore_processor_top;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   multicore_processor_top dut (.clk(clk), .rst(rst));

   multicore_processor_top_if mon0 ();
   multicore_processor_top_if mon1 ();
   assign mon0.we    = dut.core0.wb_bus.we;
   assign mon0.waddr = dut.core0.wb_bus.waddr;
   assign mon0.wdata = dut.core0.wb_bus.wdata;
   assign mon1.we    = dut.core1.wb_bus.we;
   assign mon1.waddr = dut.core1.wb_bus.waddr;
   assign mon1.wdata = dut.core1.wb_bus.wdata;

   int n_checks = 0;
   int n_fail   = 0;
   int ncyc     = 0;
   logic [31:0] rom  [2][16];
   logic [31:0] mreg [2][32];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] dreg(input int c, input int i);
      return (c == 0) ? dut.core0.decode_stage.rf.registers[i] : dut.core1.decode_stage.rf.registers[i];
   endfunction

   function automatic logic [31:0] dif(input int c);
      return (c == 0) ? dut.core0.if_id.id_instruction_out : dut.core1.if_id.id_instruction_out;
   endfunction

   // ISA semantics of one instruction against the model register state.
   function automatic void eval(input int c, input logic [31:0] ins,
                                output logic w, output logic [4:0] rd, output logic [31:0] res);
      logic [31:0] a, b, imm;
      a   = mreg[c][ins[19:15]];
      b   = mreg[c][ins[24:20]];
      imm = {{20{ins[31]}}, ins[31:20]};
      rd  = ins[11:7];
      w   = 1'b0;
      res = '0;
      if (ins[6:0] == 7'h13 && ins[14:12] == 3'd0) begin
         w = 1'b1; res = a + imm;
      end else if (ins[6:0] == 7'h33 && ins[31:25] == 7'h00) begin
         case (ins[14:12])
            3'd0: begin w = 1'b1; res = a + b; end
            3'd7: begin w = 1'b1; res = a & b; end
            3'd6: begin w = 1'b1; res = a | b; end
            3'd4: begin w = 1'b1; res = a ^ b; end
            default: ;
         endcase
      end else if (ins[6:0] == 7'h33 && ins[31:25] == 7'h20 && ins[14:12] == 3'd0) begin
         w = 1'b1; res = a - b;
      end
      if (rd == 5'd0) w = 1'b0;
   endfunction

   // Model: count rising edges since release; the edge numbered k+5 retires ROM[k].
   always @(posedge clk) begin
      logic w; logic [4:0] rd; logic [31:0] res;
      if (!rst) begin
         ncyc = 0;
         for (int c = 0; c < 2; c++) for (int i = 0; i < 32; i++) mreg[c][i] = '0;
      end else begin
         ncyc++;
         if (ncyc >= 5 && ncyc <= 20) begin
            for (int c = 0; c < 2; c++) begin
               eval(c, rom[c][ncyc-5], w, rd, res);
               if (w) mreg[c][rd] = res;
            end
         end
      end
   end

   always @(negedge clk) begin
      logic w; logic [4:0] rd; logic [31:0] res;
      logic [31:0] exp_if;
      logic [37:0] act_wb, exp_wb;
      int j;
      for (int c = 0; c < 2; c++) begin
         exp_if = (rst && ncyc >= 1 && ncyc <= 16) ? rom[c][ncyc-1] : NOP;
         chk($sformatf("c%0d_if_id", c), 64'(dif(c)), 64'(exp_if));
         for (int i = 0; i < 32; i++)
            chk($sformatf("c%0d_x%0d", c, i), 64'(dreg(c, i)), 64'(rst ? mreg[c][i] : 32'd0));
         j = ncyc - 4;
         w = 1'b0; rd = '0; res = '0;
         if (rst && j >= 0 && j < 16) eval(c, rom[c][j], w, rd, res);
         exp_wb = w ? {1'b1, rd, res} : 38'd0;
         if (c == 0) act_wb = (mon0.we && mon0.waddr != 5'd0) ? {1'b1, mon0.waddr, mon0.wdata} : 38'd0;
         else        act_wb = (mon1.we && mon1.waddr != 5'd0) ? {1'b1, mon1.waddr, mon1.wdata} : 38'd0;
         chk($sformatf("c%0d_wb_bus", c), 64'(act_wb), 64'(exp_wb));
      end
   end

   initial begin
      bit ok;
      for (int c = 0; c < 2; c++) for (int k = 0; k < 16; k++) rom[c][k] = NOP;
      rom[0][0] = 32'h0050_0093; rom[0][1] = 32'h00A0_0113; rom[0][5] = 32'h0020_81B3;
      rom[1][0] = 32'h00C0_0093; rom[1][1] = 32'h00F0_0113; rom[1][5] = 32'h0020_81B3;
      for (int c = 0; c < 2; c++) for (int i = 0; i < 32; i++) mreg[c][i] = '0;

      #18;
      chk("rst_c0_if", 64'(dif(0)), 64'(NOP));
      chk("rst_c1_if", 64'(dif(1)), 64'(NOP));
      chk("rst_c0_x1", 64'(dreg(0, 1)), 64'd0);
      chk("rst_c1_x3", 64'(dreg(1, 3)), 64'd0);
      #2 rst = 1'b1;

      @(posedge clk); #1;
      chk("first_c0_if", 64'(dif(0)), 64'h0050_0093);
      chk("first_c1_if", 64'(dif(1)), 64'h00C0_0093);

      repeat (24) @(posedge clk);
      #1;
      chk("run_c0_x3", 64'(dreg(0, 3)), 64'd15);
      chk("run_c1_x3", 64'(dreg(1, 3)), 64'd27);
      chk("indep_c0_x1", 64'(dreg(0, 1)), 64'd5);
      chk("indep_c1_x1", 64'(dreg(1, 1)), 64'd12);
      chk("run_c0_x2", 64'(dreg(0, 2)), 64'd10);
      chk("run_c1_x2", 64'(dreg(1, 2)), 64'd15);

      for (int ep = 0; ep < 8; ep++) begin
         repeat ($urandom_range(1, 22)) @(posedge clk);
         @(negedge clk);
         #($urandom_range(1, 3)) rst = 1'b0;
         #1;
         for (int c = 0; c < 2; c++) begin
            for (int i = 1; i < 4; i++)
               chk($sformatf("async_clr_c%0d_x%0d", c, i), 64'(dreg(c, i)), 64'd0);
            chk($sformatf("async_clr_c%0d_if", c), 64'(dif(c)), 64'(NOP));
         end
         repeat ($urandom_range(1, 4)) @(negedge clk);
         #($urandom_range(1, 3)) rst = 1'b1;
         ok = 1'b0;
         for (int i = 0; i < 10 && !ok; i++) begin
            @(posedge clk); #1;
            ok = (dreg(0, 3) == 32'd15) && (dreg(1, 3) == 32'd27);
         end
         chk("recover_c0_x3", 64'(dreg(0, 3)), 64'd15);
         chk("recover_c1_x3", 64'(dreg(1, 3)), 64'd27);
      end

      repeat (5) @(posedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
